operand_gen_pipe: RTL and testbench
===================================

Name: operand_gen_pipe

Overview:
- Parametrised, registered successor to the decode-stage operand generator.
- Takes a decoded instruction from ID and selects operand_1/operand_2: register, link address, or extended immediate.
- Resolves register operands against FWD_CHANNELS forwarding sources from later stages.
- Stalls on a pending (load-use) match and presents operands to EX through a valid/ready register slice with 1-cycle latency.

Parameters:
- DATA_WIDTH, 32, datapath and address width; must be >= IMM_WIDTH.
- IMM_WIDTH, 16, immediate field width.
- REG_ADDR_WIDTH, 5, register index width.
- FWD_CHANNELS, 2, number of forwarding sources; channel 0 is the youngest and has highest priority.
- LINK_OFFSET, 8, added to addr to form the link address.
- STALL_CNT_WIDTH, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low.
- flush  in  1  discard held output and any stall; same cycle as accept = flush wins.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  operand_gen_pipe accepts this cycle.
- addr  in  DATA_WIDTH  instruction PC.
- op  in  6  opcode.
- funct  in  6  function field.
- imm  in  IMM_WIDTH  immediate field.
- rs_addr, rt_addr  in  REG_ADDR_WIDTH each  source register indices.
- reg_data_1, reg_data_2  in  DATA_WIDTH each  register file read data for rs/rt.
- fwd_we  in  FWD_CHANNELS  per-channel write enable.
- fwd_pend  in  FWD_CHANNELS  per-channel result-not-yet-available flag (load in EX).
- fwd_addr  in  FWD_CHANNELS*REG_ADDR_WIDTH  per-channel destination, channel i at [i*W +: W].
- fwd_data  in  FWD_CHANNELS*DATA_WIDTH  per-channel result.
- out_valid  out  1  operands valid for EX.
- out_ready  in  1  EX consumes.
- operand_1, operand_2  out  DATA_WIDTH each  registered operands.
- stall_cycles  out  STALL_CNT_WIDTH  saturating count of hazard stall cycles.

Behaviour:
- Reset (rst=0 at edge): out_valid=0, operand_1=0, operand_2=0, stall_cycles=0, state=EMPTY. Reset mid-stall or mid-hold drops the instruction.
- Operand select, all widths parametrised:
  - sign_ext = imm sign-extended.
  - zero_lo = imm zero-extended.
  - zero_hi = imm in the top IMM_WIDTH bits, zeros below.
  - link = addr + LINK_OFFSET, modulo 2^DATA_WIDTH.
- operand_1:
  - rs value for ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F, LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
  - SPECIAL 0x00: link if funct=JALR 0x09, else rs value.
  - JAL 0x03: link.
  - Otherwise 0.
- operand_2:
  - LUI: zero_hi.
  - ANDI/ORI/XORI: zero_lo.
  - ADDIU/SLTI/SLTIU and all loads/stores: sign_ext.
  - SPECIAL: rt value.
  - Otherwise 0.
- Forwarding:
  - "rs value" = data of the lowest-index channel with fwd_we=1 and fwd_addr==rs_addr, else reg_data_1. "rt value" likewise with rt_addr and reg_data_2.
  - Index 0 never matches; register 0 always reads reg_data.
  - Only operands actually used by the opcode participate.
- Hazard: the winning matched channel has fwd_pend=1 for a used operand. A pending channel shadowed by a lower-index non-pending match is not a hazard.
- in_ready = !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Operands register on that edge and out_valid=1 next cycle (latency 1). Back-to-back accepts sustain 1 instruction/cycle.
- out_valid && !out_ready: operand_1/operand_2 hold stable; no new accept.
- out_valid && out_ready && no accept: out_valid -> 0.
- States (implementation: out_valid plus a stall flag):
  - EMPTY -> FULL on accept.
  - EMPTY/FULL -> STALL when in_valid && hazard.
  - STALL -> FULL on accept once the pend clears.
  - FULL -> EMPTY on consume without accept.
  - Any state -> EMPTY on flush.
- Flush: next edge out_valid=0, no accept that cycle, in_ready=0 during flush. stall_cycles is not cleared.
- stall_cycles increments each cycle with in_valid && hazard && !flush and saturates at all-ones.
- in_valid=0 is never a hazard and never counts.

Test Plan:
- ADDIU, imm=0xFFFC, reg_data_1=0x10, no forwarding -> operand_1=0x00000010, operand_2=0xFFFFFFFC one cycle after accept.
- LUI imm=0x1234 -> operand_2=0x12340000. ORI imm=0x8001 -> operand_2=0x00008001. JAL addr=0x00400000 -> operand_1=0x00400008, operand_2=0.
- SPECIAL ADDU, rs=3, rt=4:
  - ch0 we=1, addr=3, data=0xAAAA; ch1 we=1, addr=3, data=0xBBBB; ch1 addr=4, data=0xCCCC -> operand_1=0xAAAA (ch0 wins).
  - Second case, ch1 addr=4, data=0xCCCC -> operand_2=0xCCCC.
  - Repeat with rs=0 and ch0 addr=0 -> reg_data_1 is used.
- Load-use: ch0 pend=1, addr=rs for 2 cycles, then pend=0, data=0x55 -> in_ready=0 for 2 cycles, stall_cycles=2, then accept with operand_1=0x55.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> operands stable, in_ready=0. Release -> one instruction per cycle, no loss or duplication.
- Flush while FULL and in STALL -> out_valid=0 next cycle. rst=0 mid-stall -> all outputs 0 and stall_cycles=0 next edge.

Source files
------------

// File: rtl/operand_gen_pipe_if.sv
// operand_gen_pipe_if: handshake and datapath bundle between ID, the
// forwarding network, the operand generator and EX.
interface operand_gen_pipe_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMM_WIDTH       = 16,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int FWD_CHANNELS    = 2,
    parameter int STALL_CNT_WIDTH = 16
);
    logic                                   flush;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [DATA_WIDTH-1:0]                  addr;
    logic [5:0]                             op;
    logic [5:0]                             funct;
    logic [IMM_WIDTH-1:0]                   imm;
    logic [REG_ADDR_WIDTH-1:0]              rs_addr;
    logic [REG_ADDR_WIDTH-1:0]              rt_addr;
    logic [DATA_WIDTH-1:0]                  reg_data_1;
    logic [DATA_WIDTH-1:0]                  reg_data_2;
    logic [FWD_CHANNELS-1:0]                fwd_we;
    logic [FWD_CHANNELS-1:0]                fwd_pend;
    logic [FWD_CHANNELS*REG_ADDR_WIDTH-1:0] fwd_addr;
    logic [FWD_CHANNELS*DATA_WIDTH-1:0]     fwd_data;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [DATA_WIDTH-1:0]                  operand_1;
    logic [DATA_WIDTH-1:0]                  operand_2;
    logic [STALL_CNT_WIDTH-1:0]             stall_cycles;

    modport master (
        output flush, in_valid, addr, op, funct, imm,
        output rs_addr, rt_addr, reg_data_1, reg_data_2,
        output fwd_we, fwd_pend, fwd_addr, fwd_data, out_ready,
        input  in_ready, out_valid, operand_1, operand_2, stall_cycles
    );

    modport slave (
        input  flush, in_valid, addr, op, funct, imm,
        input  rs_addr, rt_addr, reg_data_1, reg_data_2,
        input  fwd_we, fwd_pend, fwd_addr, fwd_data, out_ready,
        output in_ready, out_valid, operand_1, operand_2, stall_cycles
    );
endinterface

// File: rtl/operand_gen_pipe.sv
// operand_gen_pipe: selects and forwards EX operands, stalls on load-use
// hazards and hands results to EX through a 1-deep valid/ready slice.
module operand_gen_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMM_WIDTH       = 16,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int FWD_CHANNELS    = 2,
    parameter int LINK_OFFSET     = 8,
    parameter int STALL_CNT_WIDTH = 16
) (
    input logic                clk,
    input logic                rst,
    operand_gen_pipe_if.slave  bus
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [1:0] S1_ZERO = 2'd0;
    localparam logic [1:0] S1_RS   = 2'd1;
    localparam logic [1:0] S1_LINK = 2'd2;

    localparam logic [2:0] S2_ZERO = 3'd0;
    localparam logic [2:0] S2_RT   = 3'd1;
    localparam logic [2:0] S2_SEXT = 3'd2;
    localparam logic [2:0] S2_ZLO  = 3'd3;
    localparam logic [2:0] S2_ZHI  = 3'd4;

    localparam int RW = REG_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic [1:0]                 w_sel1;
    logic [2:0]                 w_sel2;
    logic                       w_use_rs;
    logic                       w_use_rt;
    logic [DW-1:0]              w_rs_val;
    logic [DW-1:0]              w_rt_val;
    logic                       w_rs_pend;
    logic                       w_rt_pend;
    logic [DW-1:0]              w_sext;
    logic [DW-1:0]              w_zlo;
    logic [DW-1:0]              w_zhi;
    logic [DW-1:0]              w_link;
    logic [DW-1:0]              w_op1;
    logic [DW-1:0]              w_op2;
    logic                       w_hazard;
    logic                       w_accept;

    logic                       r_valid;
    logic [DW-1:0]              r_op1;
    logic [DW-1:0]              r_op2;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    assign w_sext = DW'($signed(bus.imm));
    assign w_zlo  = DW'(bus.imm);
    assign w_zhi  = DW'(bus.imm) << (DW - IMM_WIDTH);
    assign w_link = bus.addr + DW'(LINK_OFFSET);

    // Decode opcode into operand source selects.
    always_comb begin
        w_sel1 = S1_ZERO;
        w_sel2 = S2_ZERO;
        case (bus.op)
            OP_SPECIAL: begin
                w_sel1 = (bus.funct == FN_JALR) ? S1_LINK : S1_RS;
                w_sel2 = S2_RT;
            end
            OP_JAL: w_sel1 = S1_LINK;
            OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: begin
                w_sel1 = S1_RS;
                w_sel2 = S2_SEXT;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                w_sel1 = S1_RS;
                w_sel2 = S2_ZLO;
            end
            OP_LUI: begin
                w_sel1 = S1_RS;
                w_sel2 = S2_ZHI;
            end
            default: begin
                w_sel1 = S1_ZERO;
                w_sel2 = S2_ZERO;
            end
        endcase
    end

    assign w_use_rs = (w_sel1 == S1_RS);
    assign w_use_rt = (w_sel2 == S2_RT);

    // Forward rs/rt; walking down makes the lowest channel win.
    always_comb begin
        w_rs_val  = bus.reg_data_1;
        w_rt_val  = bus.reg_data_2;
        w_rs_pend = 1'b0;
        w_rt_pend = 1'b0;
        for (int i = FWD_CHANNELS - 1; i >= 0; i--) begin
            if (bus.fwd_we[i] && bus.rs_addr != '0 &&
                bus.fwd_addr[i*RW +: RW] == bus.rs_addr) begin
                w_rs_val  = bus.fwd_data[i*DW +: DW];
                w_rs_pend = bus.fwd_pend[i];
            end
            if (bus.fwd_we[i] && bus.rt_addr != '0 &&
                bus.fwd_addr[i*RW +: RW] == bus.rt_addr) begin
                w_rt_val  = bus.fwd_data[i*DW +: DW];
                w_rt_pend = bus.fwd_pend[i];
            end
        end
    end

    // Mux the selected sources onto the operand buses.
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        case (w_sel1)
            S1_RS:   w_op1 = w_rs_val;
            S1_LINK: w_op1 = w_link;
            default: w_op1 = '0;
        endcase
        case (w_sel2)
            S2_RT:   w_op2 = w_rt_val;
            S2_SEXT: w_op2 = w_sext;
            S2_ZLO:  w_op2 = w_zlo;
            S2_ZHI:  w_op2 = w_zhi;
            default: w_op2 = '0;
        endcase
    end

    assign w_hazard = bus.in_valid &&
                      ((w_use_rs && w_rs_pend) || (w_use_rt && w_rt_pend));
    assign bus.in_ready = !bus.flush && !w_hazard &&
                          (!r_valid || bus.out_ready);
    assign w_accept = bus.in_valid && bus.in_ready;

    // Output slice: load on accept, drain on consume, drop on flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating count of cycles lost to hazard stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !bus.flush && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.out_valid    = r_valid;
    assign bus.operand_1    = r_op1;
    assign bus.operand_2    = r_op2;
    assign bus.stall_cycles = r_stall_cnt;
endmodule

// File: tb/tb_operand_gen_pipe.sv
// tb_operand_gen_pipe: scoreboard bench for the operand generator,
// covering decode, forwarding, load-use stalls, backpressure and flush.
module tb_operand_gen_pipe;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;
    logic [63:0] sb_q[$];

    operand_gen_pipe_if bus ();

    operand_gen_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count for throughput checks.
    always @(posedge clk) cyc++;

    // Scoreboard: every consumed output must match the oldest expected.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && bus.out_valid && bus.out_ready && !bus.flush) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected got op1=%h op2=%h, none expected",
                         bus.operand_1, bus.operand_2);
            end else begin
                e = sb_q.pop_front();
                if ({bus.operand_1, bus.operand_2} !== e) begin
                    n_err++;
                    $display("FAIL sb_operands got %h_%h want %h_%h",
                             bus.operand_1, bus.operand_2, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic [15:0] imm, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [31:0] rd1,
                             input logic [31:0] rd2, input logic [31:0] pc);
        bus.op = op;
        bus.funct = fn;
        bus.imm = imm;
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        bus.reg_data_1 = rd1;
        bus.reg_data_2 = rd2;
        bus.addr = pc;
    endtask

    task automatic set_fwd(input int ch, input logic we, input logic pend,
                           input logic [4:0] a, input logic [31:0] d);
        bus.fwd_we[ch] = we;
        bus.fwd_pend[ch] = pend;
        bus.fwd_addr[ch*5 +: 5] = a;
        bus.fwd_data[ch*32 +: 32] = d;
    endtask

    task automatic clear_fwd();
        bus.fwd_we = '0;
        bus.fwd_pend = '0;
        bus.fwd_addr = '0;
        bus.fwd_data = '0;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Present the current instruction until accepted; push its expectation.
    task automatic send(input logic [63:0] exp, input string name);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(exp);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s accept timeout got in_ready=0 want 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        set_instr(6'h00, 6'h00, 16'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        clear_fwd();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_operand_1", bus.operand_1, 32'h0);
        check("rst_operand_2", bus.operand_2, 32'h0);
        check("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_imm();
        set_instr(6'h09, 6'h00, 16'hFFFC, 5'd1, 5'd2, 32'h10, 32'h0, 32'h0);
        send({32'h10, 32'hFFFF_FFFC}, "addiu");
        @(negedge clk);
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        check("latency_operand_1", bus.operand_1, 32'h10);
        @(posedge clk);
        #1;
        set_instr(6'h0F, 6'h00, 16'h1234, 5'd1, 5'd2, 32'h77, 32'h0, 32'h0);
        send({32'h77, 32'h1234_0000}, "lui");
        set_instr(6'h0D, 6'h00, 16'h8001, 5'd1, 5'd2, 32'h5, 32'h0, 32'h0);
        send({32'h5, 32'h0000_8001}, "ori");
        set_instr(6'h03, 6'h00, 16'h0, 5'd1, 5'd2, 32'h5, 32'h6, 32'h0040_0000);
        send({32'h0040_0008, 32'h0}, "jal");
        set_instr(6'h00, 6'h09, 16'h0, 5'd1, 5'd2, 32'h5, 32'h99, 32'h1000);
        send({32'h1008, 32'h99}, "jalr");
        set_instr(6'h23, 6'h00, 16'h8000, 5'd1, 5'd2, 32'h100, 32'h0, 32'h0);
        send({32'h100, 32'hFFFF_8000}, "lw");
        set_instr(6'h3F, 6'h00, 16'h1234, 5'd1, 5'd2, 32'h5, 32'h6, 32'h0);
        send({32'h0, 32'h0}, "unknown_op");
    endtask

    task automatic test_forward();
        set_instr(6'h00, 6'h21, 16'h0, 5'd3, 5'd4, 32'h11, 32'h22, 32'h0);
        set_fwd(0, 1, 0, 5'd3, 32'hAAAA);
        set_fwd(1, 1, 0, 5'd3, 32'hBBBB);
        send({32'hAAAA, 32'h22}, "fwd_ch0_wins");
        set_fwd(1, 1, 0, 5'd4, 32'hCCCC);
        send({32'hAAAA, 32'hCCCC}, "fwd_rt_ch1");
        bus.rs_addr = 5'd0;
        set_fwd(0, 1, 0, 5'd0, 32'hDDDD);
        send({32'h11, 32'hCCCC}, "fwd_r0");
        bus.rs_addr = 5'd3;
        set_fwd(0, 1, 0, 5'd3, 32'hAAAA);
        set_fwd(1, 1, 1, 5'd3, 32'hBBBB);
        send({32'hAAAA, 32'h22}, "fwd_shadowed_pend");
        set_instr(6'h09, 6'h00, 16'h0004, 5'd3, 5'd4, 32'h11, 32'h22, 32'h0);
        clear_fwd();
        set_fwd(0, 1, 1, 5'd4, 32'hEEEE);
        send({32'h11, 32'h4}, "fwd_unused_rt_pend");
        clear_fwd();
        set_instr(6'h00, 6'h21, 16'h0, 5'd3, 5'd4, 32'h11, 32'h22, 32'h0);
        set_fwd(0, 0, 0, 5'd3, 32'hAAAA);
        send({32'h11, 32'h22}, "fwd_we_off");
        clear_fwd();
        @(negedge clk);
        check("fwd_no_stalls", 32'(bus.stall_cycles), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        set_instr(6'h09, 6'h00, 16'h0001, 5'd5, 5'd6, 32'h1, 32'h0, 32'h0);
        set_fwd(0, 1, 1, 5'd5, 32'h0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lu_in_ready_stall", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        set_fwd(0, 1, 0, 5'd5, 32'h55);
        @(negedge clk);
        check("lu_stall_cycles", 32'(bus.stall_cycles), 32'd2);
        check("lu_in_ready_clear", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) sb_q.push_back({32'h55, 32'h1});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
        check("lu_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int c0;
        bus.out_ready = 1'b0;
        set_instr(6'h09, 6'h00, 16'h0001, 5'd1, 5'd2, 32'h100, 32'h0, 32'h0);
        send({32'h100, 32'h1}, "bp_first");
        set_instr(6'h0D, 6'h00, 16'h0002, 5'd1, 5'd2, 32'h200, 32'h0, 32'h0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_op1", bus.operand_1, 32'h100);
            check("bp_hold_op2", bus.operand_2, 32'h1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        c0 = cyc;
        send({32'h200, 32'h2}, "bp_y");
        set_instr(6'h0C, 6'h00, 16'h0003, 5'd1, 5'd2, 32'h300, 32'h0, 32'h0);
        send({32'h300, 32'h3}, "bp_z");
        set_instr(6'h0E, 6'h00, 16'h0004, 5'd1, 5'd2, 32'h400, 32'h0, 32'h0);
        send({32'h400, 32'h4}, "bp_w");
        check("b2b_cycles", 32'(cyc - c0), 32'd3);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("bp_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        set_instr(6'h09, 6'h00, 16'h0001, 5'd1, 5'd2, 32'h42, 32'h0, 32'h0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("fl_full_valid", 32'(bus.out_valid), 32'd1);
        check("fl_full_op1", bus.operand_1, 32'h42);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("fl_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("fl_full_cleared", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        set_fwd(0, 1, 1, 5'd1, 32'h0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("fl_stall_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
        check("fl_stall_valid", 32'(bus.out_valid), 32'd0);
        check("fl_stall_cnt_kept", 32'(bus.stall_cycles), 32'd3);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_stall();
        bus.out_ready = 1'b0;
        set_instr(6'h09, 6'h00, 16'h0001, 5'd1, 5'd2, 32'h42, 32'h0, 32'h0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        set_fwd(0, 1, 1, 5'd1, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rs_pre_stall_cnt", 32'(bus.stall_cycles), 32'd5);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
        check("rs_out_valid", 32'(bus.out_valid), 32'd0);
        check("rs_operand_1", bus.operand_1, 32'h0);
        check("rs_operand_2", bus.operand_2, 32'h0);
        check("rs_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        test_reset();
        test_imm();
        test_forward();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        check("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
